// File: rtl/ext_pkg.sv
// ext_pkg: mode encodings and illegal-mode predicate shared by ext_core/ext_pipe; EXT_PC_EN adds the J mode.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ext_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] EXT_ZERO = 3'd0;
    localparam logic [MODE_W-1:0] EXT_SIGN = 3'd1;
    localparam logic [MODE_W-1:0] EXT_LUI  = 3'd2;
    localparam logic [MODE_W-1:0] EXT_BR   = 3'd3;
    localparam logic [MODE_W-1:0] EXT_J    = 3'd4;

    // J only exists when the PC path is built; otherwise it joins codes 5-7 as illegal.
    function automatic logic is_illegal_mode(input logic [MODE_W-1:0] mode);
`ifdef EXT_PC_EN
        return (mode > EXT_J);
`else
        return (mode > EXT_BR);
`endif
    endfunction

endpackage

// File: rtl/ext_core.sv
// ext_core: combinational immediate extender (zero/sign/lui/branch, plus PC-relative BR and J under EXT_PC_EN).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module ext_core
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int JIDX_W = 26,
    parameter int DATA_W = 32
) (
    input  logic [MODE_W-1:0] i_mode,
    input  logic [IMM_W-1:0]  i_imm,
    input  logic [JIDX_W-1:0] i_jidx,
    input  logic [DATA_W-1:0] i_pc,
    output logic [DATA_W-1:0] o_data,
    output logic              o_illegal
);

    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_lui;
    logic [DATA_W-1:0] w_boff;
    logic [DATA_W-1:0] w_br;

    assign w_zext = {{(DATA_W-IMM_W){1'b0}}, i_imm};
    assign w_sext = {{(DATA_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
    assign w_lui  = {i_imm, {(DATA_W-IMM_W){1'b0}}};
    // Word-aligned branch offset; the two sign bits shifted out are redundant copies.
    assign w_boff = {w_sext[DATA_W-3:0], 2'b00};

`ifdef EXT_PC_EN
    logic [DATA_W-1:0] w_pc4;
    logic [DATA_W-1:0] w_j;
    logic [JIDX_W+1:0] w_pc4_low_unused;

    assign w_pc4            = i_pc + DATA_W'(4);
    assign w_br             = w_pc4 + w_boff;
    // Jump keeps the region bits of the next PC and replaces the rest with the word index.
    assign w_j              = {w_pc4[DATA_W-1:JIDX_W+2], i_jidx, 2'b00};
    assign w_pc4_low_unused = w_pc4[JIDX_W+1:0];
`else
    logic [DATA_W+JIDX_W-1:0] w_pc_jidx_unused;

    // Without the PC path a branch yields only its offset; PC and jump index are ignored.
    assign w_br             = w_boff;
    assign w_pc_jidx_unused = {i_pc, i_jidx};
`endif

    // Mode select; illegal codes fall through to zero-extension so the beat still carries data.
    always_comb begin
        o_illegal = is_illegal_mode(i_mode);
        o_data    = w_zext;
        case (i_mode)
            EXT_SIGN: o_data = w_sext;
            EXT_LUI:  o_data = w_lui;
            EXT_BR:   o_data = w_br;
`ifdef EXT_PC_EN
            EXT_J:    o_data = w_j;
`endif
            default:  o_data = w_zext;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate-extension stage with skid buffer, flush and sticky illegal-mode flag; EXT_PC_EN enables PC-relative BR/J.
// Latency: accept at edge N -> result on out_data during cycle N+1; one beat per cycle while out_ready is high.
// Backpressure: in_ready = skid empty (registered only); a stalled output parks one more beat in the skid, two beats max.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int JIDX_W = 26,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [JIDX_W-1:0] in_jidx,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              err,
    input  logic              err_clr
);

    logic              r_out_vld;
    logic [DATA_W-1:0] r_out_dat;
    logic              r_skid_vld;
    logic [DATA_W-1:0] r_skid_dat;
    logic              r_err;

    logic [DATA_W-1:0] w_ext_dat;
    logic              w_ext_illegal;
    logic              w_accept;
    logic              w_out_free;

    // Result is computed once at the input and only moved afterwards.
    ext_core #(
        .IMM_W  (IMM_W),
        .JIDX_W (JIDX_W),
        .DATA_W (DATA_W)
    ) u_core (
        .i_mode    (in_mode),
        .i_imm     (in_imm),
        .i_jidx    (in_jidx),
        .i_pc      (in_pc),
        .o_data    (w_ext_dat),
        .o_illegal (w_ext_illegal)
    );

    assign in_ready   = ~r_skid_vld;
    assign w_accept   = in_valid & in_ready;
    // R can take a new beat when it is empty or being consumed this cycle.
    assign w_out_free = ~r_out_vld | out_ready;

    // R/S movement: refill R from S first (FIFO order), else from the input; park input in S only while R stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_vld  <= 1'b0;
            r_out_dat  <= '0;
            r_skid_vld <= 1'b0;
            r_skid_dat <= '0;
        end else if (flush) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_vld) begin
                r_out_vld  <= 1'b1;
                r_out_dat  <= r_skid_dat;
                r_skid_vld <= 1'b0;
            end else if (w_accept) begin
                r_out_vld <= 1'b1;
                r_out_dat <= w_ext_dat;
            end else begin
                r_out_vld <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_vld <= 1'b1;
            r_skid_dat <= w_ext_dat;
        end
    end

    // Sticky illegal flag: an illegal accept that survives flush sets it and beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_accept && w_ext_illegal && !flush) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign out_valid = r_out_vld;
    assign out_data  = r_out_dat;
    assign err       = r_err;

endmodule
